// File: rtl/stream_mux_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr_if
// Description : Handshake bundle for stream_mux_rr (N_CH inputs, one output).
// Revision    : 1.0 - initial release
// ============================================================================
interface stream_mux_rr_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_ready;

    // The mux itself
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    // Producers and consumer around the mux
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
endinterface
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-channel valid/ready stream mux, fixed or round-robin select,
//               single registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_mux_rr_if.slave        bus
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [SEL_W-1:0] ptr_q,       ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;

    logic             w_load;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt;
    logic [WIDTH-1:0] w_gnt_data;
    logic [N_CH-1:0]  w_ready;

    always_comb begin
        w_load     = ~out_valid_q | bus.out_ready;
        w_gnt_vld  = 1'b0;
        w_gnt      = '0;
        w_gnt_data = '0;
        w_ready    = '0;

        if (!bus.mode) begin
            // Out-of-range sel never matches any channel, so it yields no grant.
            for (int i = 0; i < N_CH; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SEL_W'(i);
                end
            end
        end else begin
            // Scan offsets from farthest to nearest so the nearest valid channel
            // after ptr is the last one written and therefore wins.
            for (int k = N_CH - 1; k >= 0; k--) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (ptr_q == SEL_W'((i + N_CH - k) % N_CH) && bus.in_valid[i]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt     = SEL_W'(i);
                    end
                end
            end
        end

        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
            w_ready[i] = w_gnt_vld & w_load & (w_gnt == SEL_W'(i));
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (w_load) begin
            out_valid_d = w_gnt_vld;
            if (w_gnt_vld) begin
                out_data_d = w_gnt_data;
                out_ch_d   = w_gnt;
                ptr_d      = (w_gnt == SEL_W'(N_CH - 1)) ? '0 : w_gnt + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
endmodule
`default_nettype wire
